demux_a_writeback: RTL and testbench

Write-side counterpart of the operand-select multiplexer in the 4215 datapath: routes one result word into one of four operand registers chosen by a 2-bit select. The registers drive the multiplexer data inputs In_A0..In_A3 directly.
Writes are queued in a small in-order FIFO with a valid/ready handshake. The FIFO drains one entry per cycle unless the bank is frozen by Hold, so producers never collide with operand reads.

---
 rtl/demux_a_writeback_if.sv | 24 ++
 rtl/demux_a_writeback.sv | 101 ++++++++++
 tb/tb_demux_a_writeback.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/demux_a_writeback_if.sv
// Write-request channel into the operand-register write-back bank.
// The producer drives a select/data pair qualified by Wr_Valid; the bank answers with Wr_Ready.
interface demux_a_writeback_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] In_D;
  logic [1:0]       S_D;
  logic             Wr_Valid;
  logic             Wr_Ready;

  modport master (
    output In_D,
    output S_D,
    output Wr_Valid,
    input  Wr_Ready
  );

  modport slave (
    input  In_D,
    input  S_D,
    input  Wr_Valid,
    output Wr_Ready
  );
endinterface

// File: rtl/demux_a_writeback.sv
// Write-back demultiplexer for the 4215 operand bank: a small in-order FIFO of
// {select, data} writes drains one entry per cycle into one of four operand registers.
module demux_a_writeback #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  demux_a_writeback_if.slave wr_if,
  input  logic               Hold,
  output logic [WIDTH-1:0]   Out_D0,
  output logic [WIDTH-1:0]   Out_D1,
  output logic [WIDTH-1:0]   Out_D2,
  output logic [WIDTH-1:0]   Out_D3,
  output logic               Busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][EW-1:0] mem_q;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [3:0][WIDTH-1:0]    reg_q, reg_d;

  logic          ready_s;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] head_s;

  // Handshake and pop qualifiers, all from pre-edge state (no look-ahead on a same-cycle pop).
  always_comb begin
    ready_s = (count_q < DEPTH_C);
    push_s  = wr_if.Wr_Valid & ready_s;
    pop_s   = (count_q != {CW{1'b0}}) & ~Hold;
    head_s  = mem_q[rd_ptr_q];
  end

  // Next-state for pointers, occupancy and the register bank.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    reg_d    = reg_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      case (head_s[WIDTH+1:WIDTH])
        2'b00:   reg_d[0] = head_s[WIDTH-1:0];
        2'b01:   reg_d[1] = head_s[WIDTH-1:0];
        2'b10:   reg_d[2] = head_s[WIDTH-1:0];
        2'b11:   reg_d[3] = head_s[WIDTH-1:0];
        default: reg_d    = reg_q;
      endcase
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any queued writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      reg_q    <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {wr_if.S_D, wr_if.In_D};
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      reg_q    <= reg_d;
    end
  end

  assign wr_if.Wr_Ready = ready_s;
  assign Busy           = (count_q != {CW{1'b0}});
  assign Out_D0         = reg_q[0];
  assign Out_D1         = reg_q[1];
  assign Out_D2         = reg_q[2];
  assign Out_D3         = reg_q[3];

endmodule

// File: tb/tb_demux_a_writeback.sv
// Directed bench for demux_a_writeback: a queue/array model predicts the bank every cycle,
// and hand-computed literals pin the key points of each scenario.
module tb_demux_a_writeback;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             Clk;
  logic             Reset;
  logic             Hold;
  logic [WIDTH-1:0] Out_D0, Out_D1, Out_D2, Out_D3;
  logic             Busy;

  demux_a_writeback_if #(.WIDTH(WIDTH)) wif ();

  demux_a_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .wr_if  (wif),
    .Hold   (Hold),
    .Out_D0 (Out_D0),
    .Out_D1 (Out_D1),
    .Out_D2 (Out_D2),
    .Out_D3 (Out_D3),
    .Busy   (Busy)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model state: pending writes as {sel, data} and the four registers.
  logic [5:0] m_q[$];
  logic [3:0] m_reg[4];
  bit         prev_stalled = 1'b0;
  logic [5:0] prev_req;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge using the pre-edge queue occupancy.
  always @(posedge Clk) begin
    bit         do_pop;
    bit         do_push;
    logic [5:0] head;
    if (Reset) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled && wif.Wr_Valid)
        chk("producer_stable", {2'b00, wif.S_D, wif.In_D}, {2'b00, prev_req});
      do_pop  = (m_q.size() > 0) && !Hold;
      do_push = wif.Wr_Valid && (m_q.size() < DEPTH);
      prev_stalled = wif.Wr_Valid && !(m_q.size() < DEPTH);
      prev_req = {wif.S_D, wif.In_D};
      if (do_pop) begin
        head = m_q.pop_front();
        m_reg[head[5:4]] = head[3:0];
      end
      if (do_push) m_q.push_back({wif.S_D, wif.In_D});
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_Out_D0", {4'd0, Out_D0}, {4'd0, m_reg[0]});
      chk("model_Out_D1", {4'd0, Out_D1}, {4'd0, m_reg[1]});
      chk("model_Out_D2", {4'd0, Out_D2}, {4'd0, m_reg[2]});
      chk("model_Out_D3", {4'd0, Out_D3}, {4'd0, m_reg[3]});
      chk("model_Busy", {7'd0, Busy}, {7'd0, (m_q.size() != 0)});
      chk("model_Wr_Ready", {7'd0, wif.Wr_Ready}, {7'd0, (m_q.size() < DEPTH)});
    end
  end

  // Present one request at the current falling edge; it is accepted on the next rising edge.
  task automatic drive(input logic [1:0] sel, input logic [3:0] d);
    wif.Wr_Valid = 1'b1;
    wif.S_D      = sel;
    wif.In_D     = d;
    @(negedge Clk);
  endtask

  task automatic idle();
    wif.Wr_Valid = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    Hold  = 1'b0;
    wif.Wr_Valid = 1'b0;
    wif.S_D  = 2'b00;
    wif.In_D = 4'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_en = 1'b1;
    Reset  = 1'b0;
    chk("reset_outs", {Out_D3, Out_D2, Out_D1, Out_D0} == 16'h0000 ? 8'd1 : 8'd0, 8'd1);
    chk("reset_busy_ready", {6'd0, Busy, wif.Wr_Ready}, 8'b0000_0001);

    // 1: single write, visible one edge after acceptance
    drive(2'b11, 4'b1000);
    wif.Wr_Valid = 1'b0;
    chk("t1_busy_after_push", {7'd0, Busy}, 8'd1);
    chk("t1_no_bypass", {4'd0, Out_D3}, 8'h00);
    @(negedge Clk);
    chk("t1_out3", {4'd0, Out_D3}, 8'h08);
    chk("t1_out012", {Out_D2, Out_D1, Out_D0} == 12'h000 ? 8'd1 : 8'd0, 8'd1);
    chk("t1_busy_clear", {7'd0, Busy}, 8'd0);

    // 2: one write per cycle to each register
    drive(2'b00, 4'b0001);
    chk("t2_ready_a", {7'd0, wif.Wr_Ready}, 8'd1);
    drive(2'b01, 4'b0010);
    chk("t2_ready_b", {7'd0, wif.Wr_Ready}, 8'd1);
    drive(2'b10, 4'b0100);
    chk("t2_ready_c", {7'd0, wif.Wr_Ready}, 8'd1);
    drive(2'b11, 4'b1000);
    idle();
    chk("t2_bank", {Out_D3, Out_D2, Out_D1, Out_D0} == 16'h8421 ? 8'd1 : 8'd0, 8'd1);

    // 3: fill under Hold, stall a third request, then release
    Hold = 1'b1;
    drive(2'b01, 4'b0101);
    drive(2'b01, 4'b1010);
    chk("t3_full_ready", {7'd0, wif.Wr_Ready}, 8'd0);
    chk("t3_held_out1", {4'd0, Out_D1}, 8'h02);
    drive(2'b01, 4'b1111);
    chk("t3_still_refused", {7'd0, wif.Wr_Ready}, 8'd0);
    chk("t3_still_held", {4'd0, Out_D1}, 8'h02);
    Hold = 1'b0;
    @(negedge Clk);
    chk("t3_first_pop", {4'd0, Out_D1}, 8'h05);
    chk("t3_ready_again", {7'd0, wif.Wr_Ready}, 8'd1);
    @(negedge Clk);
    wif.Wr_Valid = 1'b0;
    chk("t3_second_pop", {4'd0, Out_D1}, 8'h0A);
    @(negedge Clk);
    chk("t3_stalled_commit", {4'd0, Out_D1}, 8'h0F);
    chk("t3_drained", {7'd0, Busy}, 8'd0);

    // 4: streaming writes to one register across many pointer laps
    for (int i = 0; i < 16; i++) begin
      drive(2'b10, 4'(i));
      chk("t4_ready", {7'd0, wif.Wr_Ready}, 8'd1);
    end
    chk("t4_second_last", {4'd0, Out_D2}, 8'h0E);
    idle();
    chk("t4_final", {4'd0, Out_D2}, 8'h0F);

    // 5: reset discards queued writes and a same-cycle request
    Hold = 1'b1;
    drive(2'b00, 4'b0011);
    drive(2'b01, 4'b0110);
    Reset = 1'b1;
    wif.Wr_Valid = 1'b1;
    wif.S_D  = 2'b10;
    wif.In_D = 4'b1001;
    @(negedge Clk);
    Reset = 1'b0;
    wif.Wr_Valid = 1'b0;
    Hold = 1'b0;
    chk("t5_outs_zero", {Out_D3, Out_D2, Out_D1, Out_D0} == 16'h0000 ? 8'd1 : 8'd0, 8'd1);
    chk("t5_busy_ready", {6'd0, Busy, wif.Wr_Ready}, 8'b0000_0001);
    repeat (3) @(negedge Clk);
    chk("t5_never_commit", {Out_D3, Out_D2, Out_D1, Out_D0} == 16'h0000 ? 8'd1 : 8'd0, 8'd1);

    // 6: push and pop on the same edge
    drive(2'b00, 4'b0110);
    drive(2'b11, 4'b0011);
    wif.Wr_Valid = 1'b0;
    chk("t6_out0", {4'd0, Out_D0}, 8'h06);
    chk("t6_count_one", {7'd0, Busy}, 8'd1);
    chk("t6_out3_not_yet", {4'd0, Out_D3}, 8'h00);
    @(negedge Clk);
    chk("t6_out3", {4'd0, Out_D3}, 8'h03);
    chk("t6_idle", {7'd0, Busy}, 8'd0);

    @(negedge Clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
